am_meas_ctrl: RTL
=================

AM_MEAS_CTRL -- requirements
Module: am_meas_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 8192, is the number of clk cycles demod_en stays high before result strobes are accepted.
REQ-002 Parameter AVG_LOG2, default 2, sets the number of collected samples to N = 2^AVG_LOG2; the legal range is 0..4.
REQ-003 Parameter TIMEOUT_CYC, default 1048576, is the maximum number of cycles spent in COLLECT.
REQ-004 Port clk, input, 1 bit: the single clock (8.192 MHz).
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port start, input, 1 bit: single-cycle request to begin one measurement.
REQ-007 Port demod_en, output, 1 bit: enable to the AM demodulator datapath.
REQ-008 Port meas_stb, input, 1 bit: single-cycle strobe marking that ma_in and freq_in are valid.
REQ-009 Port ma_in, input, 8 bits: modulation depth in percent, 0..100.
REQ-010 Port freq_in, input, 8 bits: modulation frequency in kHz.
REQ-011 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 Port res_valid, output, 1 bit: result available.
REQ-013 Port res_ready, input, 1 bit: consumer accepts the result.
REQ-014 Port ma_out, output, 8 bits: averaged modulation depth.
REQ-015 Port freq_out, output, 8 bits: averaged modulation frequency.
REQ-016 Port timeout_err, output, 1 bit: the presented result is a timeout result.

Function
REQ-017 The controller SHALL implement the states IDLE, SETTLE, COLLECT, AVG and HOLD.
REQ-018 IDLE: start=1 SHALL move to SETTLE on the next edge, clear the settle counter, the sample counter and both accumulators, and set demod_en=1 from the first SETTLE cycle.
REQ-019 SETTLE: the state SHALL advance to COLLECT after exactly SETTLE_CYC cycles; meas_stb in SETTLE SHALL be ignored.
REQ-020 COLLECT: each meas_stb=1 SHALL add ma_in and freq_in into separate accumulators of width 8+AVG_LOG2, with no overflow possible, and increment the sample count.
REQ-021 COLLECT: when the count reaches N, the state SHALL move to AVG on the same edge that accepts the Nth sample.
REQ-022 AVG: lasting 1 cycle, the block SHALL compute ma_out = (acc_ma + 2^(AVG_LOG2-1)) >> AVG_LOG2 and freq_out likewise.
REQ-023 For AVG_LOG2=0 the rounding term SHALL be 0; results above 255 are impossible by construction.
REQ-024 AVG SHALL then move to HOLD with res_valid=1, timeout_err=0 and demod_en=0.
REQ-025 COLLECT timeout: if TIMEOUT_CYC cycles elapse in COLLECT before N samples, the state SHALL move to HOLD with ma_out=0, freq_out=0, timeout_err=1, res_valid=1 and demod_en=0.
REQ-026 HOLD: ma_out, freq_out, timeout_err and res_valid SHALL stay stable until res_valid&&res_ready, then the state SHALL move to IDLE on that edge with res_valid=0 in the following cycle.
REQ-027 start while busy=1 SHALL be ignored; it is neither queued nor a restart.
REQ-028 start in the same cycle as the HOLD handshake SHALL be ignored; a new start is required in IDLE.
REQ-029 meas_stb in IDLE, AVG or HOLD SHALL be ignored.
REQ-030 If meas_stb and the timeout occur in the same cycle, the sample SHALL count first: if it is the Nth, go to AVG; otherwise take the timeout.
REQ-031 ma_out and freq_out SHALL update only in AVG or on timeout and hold their values in IDLE.
REQ-032 Latency: the Nth meas_stb edge SHALL be followed by AVG for 1 cycle, with res_valid=1 on the 2nd cycle after that strobe.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 rst_n=0 SHALL, asynchronously and at any state, force IDLE, demod_en=0, busy=0, res_valid=0, timeout_err=0, ma_out=0, freq_out=0, and clear all counters and accumulators.
REQ-035 Reset mid-measurement SHALL discard the partial data; operation SHALL resume only after rst_n=1 and a new start.
REQ-036 Outputs SHALL remain at reset values until the first start after rst_n deasserts.

Verification
REQ-037 Nominal: defaults, start, 4 strobes after settle with ma_in 30,31,30,31 and freq_in 5,5,5,5 -> ma_out=31 (rounded from 122/4), freq_out=5, res_valid=1 two cycles after the 4th strobe, timeout_err=0.
REQ-038 Settle gating: strobes at SETTLE cycles 10 and 8191 ignored, first strobe accepted at COLLECT cycle 0 -> the sum contains only post-settle samples.
REQ-039 Timeout: TIMEOUT_CYC=100, only 2 strobes -> HOLD at COLLECT cycle 100, timeout_err=1, ma_out=0, freq_out=0, demod_en=0.
REQ-040 Backpressure: res_ready=0 for 50 cycles, then 1 for one cycle -> outputs constant for 50 cycles, IDLE on the handshake edge, res_valid=0 the next cycle.
REQ-041 Busy start: start pulses in SETTLE, COLLECT and on the HOLD handshake cycle -> exactly one result, then IDLE with busy=0.
REQ-042 Async reset: rst_n low mid-COLLECT after 2 strobes, between clock edges -> outputs reset immediately; a new start plus 4 strobes of 100 -> ma_out=100.

Source files
------------

// File: rtl/am_meas_ctrl.sv
// AM measurement controller: settles the demodulator, averages N result
// strobes with rounding, and presents one result per start with a timeout.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   start               single-cycle request for one measurement
//   demod_en            enable to the AM demodulator datapath
//   meas_stb            strobe: ma_in / freq_in are valid
//   ma_in, freq_in      modulation depth (%) and frequency (kHz)
//   busy                high whenever not idle
//   res_valid/res_ready result handshake
//   ma_out, freq_out    averaged results
//   timeout_err         presented result is a timeout result
module am_meas_ctrl #(
    parameter int SETTLE_CYC  = 8192,
    parameter int AVG_LOG2    = 2,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       demod_en,
    input  logic       meas_stb,
    input  logic [7:0] ma_in,
    input  logic [7:0] freq_in,
    output logic       busy,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] ma_out,
    output logic [7:0] freq_out,
    output logic       timeout_err
);

    localparam int N    = 1 << AVG_LOG2;
    localparam int AW   = 8 + AVG_LOG2;
    // Half an LSB of the shifted result; zero when no averaging.
    localparam int RND  = N >> 1;
    localparam int CMAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SETTLE  = 3'd1;
    localparam logic [2:0] COLLECT = 3'd2;
    localparam logic [2:0] AVG     = 3'd3;
    localparam logic [2:0] HOLD    = 3'd4;

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_smp;
    logic [AW-1:0] r_acc_ma;
    logic [AW-1:0] r_acc_fq;
    logic          r_demod;
    logic          r_busy;
    logic          r_valid;
    logic          r_terr;
    logic [7:0]    r_ma;
    logic [7:0]    r_fq;

    logic          w_settle_done;
    logic          w_tmo;
    logic          w_last;
    logic [AW:0]   w_ma_rnd;
    logic [AW:0]   w_fq_rnd;
    logic [7:0]    w_ma_avg;
    logic [7:0]    w_fq_avg;

    // r_cnt counts SETTLE cycles, then is reused for COLLECT cycles.
    assign w_settle_done = (r_cnt == CW'(SETTLE_CYC - 1));
    assign w_tmo         = (r_cnt == CW'(TIMEOUT_CYC - 1));
    assign w_last        = meas_stb && (r_smp == 5'(N - 1));

    // Sum of N bytes plus N/2 never exceeds AW bits; the extra bit is slack.
    assign w_ma_rnd = {1'b0, r_acc_ma} + (AW+1)'(RND);
    assign w_fq_rnd = {1'b0, r_acc_fq} + (AW+1)'(RND);
    assign w_ma_avg = 8'(w_ma_rnd >> AVG_LOG2);
    assign w_fq_avg = 8'(w_fq_rnd >> AVG_LOG2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_smp    <= '0;
            r_acc_ma <= '0;
            r_acc_fq <= '0;
            r_demod  <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_terr   <= 1'b0;
            r_ma     <= '0;
            r_fq     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= SETTLE;
                        r_cnt    <= '0;
                        r_smp    <= '0;
                        r_acc_ma <= '0;
                        r_acc_fq <= '0;
                        r_demod  <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (w_settle_done) begin
                        r_state <= COLLECT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                COLLECT: begin
                    if (meas_stb) begin
                        r_acc_ma <= r_acc_ma + AW'(ma_in);
                        r_acc_fq <= r_acc_fq + AW'(freq_in);
                        r_smp    <= r_smp + 5'd1;
                    end
                    // A sample arriving on the timeout cycle counts first.
                    if (w_last) begin
                        r_state <= AVG;
                    end else if (w_tmo) begin
                        r_state <= HOLD;
                        r_ma    <= '0;
                        r_fq    <= '0;
                        r_terr  <= 1'b1;
                        r_valid <= 1'b1;
                        r_demod <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                AVG: begin
                    r_state <= HOLD;
                    r_ma    <= w_ma_avg;
                    r_fq    <= w_fq_avg;
                    r_terr  <= 1'b0;
                    r_valid <= 1'b1;
                    r_demod <= 1'b0;
                end
                HOLD: begin
                    if (res_ready) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_terr  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_demod <= 1'b0;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_terr  <= 1'b0;
                end
            endcase
        end
    end

    assign demod_en    = r_demod;
    assign busy        = r_busy;
    assign res_valid   = r_valid;
    assign timeout_err = r_terr;
    assign ma_out      = r_ma;
    assign freq_out    = r_fq;

endmodule
